// File: rtl/sr_latch_driver.sv
// sr_latch_driver: sequences E/S/R of a gated SR NAND latch per command,
// samples Q/Qn, checks them against a tracked expected state and reports
// pass/fail per command.
// Optional macro SR_DRV_STICKY_ERR_EN adds sticky_err: the first failure
// blocks further commands until rst.
module sr_latch_driver #(
    parameter int unsigned HOLD_CYCLES   = 1,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       latch_e,
    output logic       latch_s,
    output logic       latch_r,
    input  logic       q_in,
    input  logic       qn_in,
    output logic       rsp_valid,
    output logic       rsp_pass,
    output logic       rsp_q,
    output logic [7:0] err_count
`ifdef SR_DRV_STICKY_ERR_EN
    ,
    output logic       sticky_err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        RECOVER,
        SETTLE,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op;
    logic             exp_valid;
    logic             exp_q;
    logic             chk1;
    logic             blocked;
    logic             settle_pass;

    // {E, S, R} driven during the apply phase for each opcode
    function automatic logic [2:0] apply_drive(input logic [1:0] o);
        case (o)
            2'b01:   apply_drive = 3'b110;
            2'b10:   apply_drive = 3'b101;
            2'b11:   apply_drive = 3'b111;
            default: apply_drive = 3'b000;
        endcase
    endfunction

`ifdef SR_DRV_STICKY_ERR_EN
    assign blocked = sticky_err;
`else
    assign blocked = 1'b0;
`endif

    assign cmd_ready = (state == IDLE) && !blocked;

    // Check of the settle sample against the expected value for the current op
    always_comb begin
        settle_pass = 1'b0;
        case (op)
            2'b01: settle_pass = q_in && !qn_in;
            2'b10: settle_pass = !q_in && qn_in;
            2'b11: settle_pass = chk1 && !q_in && qn_in;
            default: begin
                if (exp_valid)
                    settle_pass = (q_in == exp_q) && (qn_in == !exp_q);
                else
                    settle_pass = (q_in != qn_in);
            end
        endcase
    end

    // Command FSM with registered latch drive and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op        <= '0;
            exp_valid <= 1'b0;
            exp_q     <= 1'b0;
            chk1      <= 1'b0;
            latch_e   <= 1'b0;
            latch_s   <= 1'b0;
            latch_r   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_pass  <= 1'b0;
            rsp_q     <= 1'b0;
            err_count <= '0;
`ifdef SR_DRV_STICKY_ERR_EN
            sticky_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op    <= cmd_op;
                        cnt   <= HOLD_LOAD;
                        state <= APPLY;
                        {latch_e, latch_s, latch_r} <= apply_drive(cmd_op);
                    end
                end
                APPLY: begin
                    if (cnt == '0) begin
                        if (op == 2'b11) begin
                            // Both outputs must be high while S=R=1; then
                            // release through reset so the latch ends defined.
                            chk1  <= q_in && qn_in;
                            exp_q <= 1'b0;
                            cnt   <= HOLD_LOAD;
                            state <= RECOVER;
                            {latch_e, latch_s, latch_r} <= 3'b101;
                        end else begin
                            cnt   <= SETTLE_LOAD;
                            state <= SETTLE;
                            {latch_e, latch_s, latch_r} <= 3'b000;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RECOVER: begin
                    if (cnt == '0) begin
                        cnt   <= SETTLE_LOAD;
                        state <= SETTLE;
                        {latch_e, latch_s, latch_r} <= 3'b000;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_pass  <= settle_pass;
                        rsp_q     <= q_in;
                        if (!settle_pass) begin
                            if (err_count != 8'hFF)
                                err_count <= err_count + 8'd1;
`ifdef SR_DRV_STICKY_ERR_EN
                            sticky_err <= 1'b1;
`endif
                        end
                        case (op)
                            2'b01: begin
                                exp_q     <= 1'b1;
                                exp_valid <= 1'b1;
                            end
                            2'b10, 2'b11: begin
                                exp_q     <= 1'b0;
                                exp_valid <= 1'b1;
                            end
                            default: ;
                        endcase
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    {latch_e, latch_s, latch_r} <= 3'b000;
                end
            endcase
        end
    end

endmodule
